pipe_skid_buf: RTL and testbench
================================

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 SHALL have parameter: WIDTH, 48, data word width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: flush  input  1  synchronous discard of all buffered words.
REQ-005 SHALL have port: in_data  input  WIDTH  word from upstream 2:1/4:1 select mux output.
REQ-006 SHALL have port: in_valid  input  1  in_data is valid.
REQ-007 SHALL have port: in_ready  output  1  buffer accepts a word this cycle.
REQ-008 SHALL have port: out_data  output  WIDTH  word to downstream stage.
REQ-009 SHALL have port: out_valid  output  1  out_data is valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port: occupancy  output  2  number of words held (0, 1 or 2).

Function
REQ-012 SHALL define input fire as in_valid & in_ready, output fire as out_valid & out_ready, both sampled at the rising edge of clk.
REQ-013 SHALL implement a state machine with states EMPTY, ONE, FULL, holding a main register and a skid register.
REQ-014 SHALL drive out_valid = (state != EMPTY), out_data = main register, occupancy = 0/1/2 for EMPTY/ONE/FULL, all from registers only.
REQ-015 SHALL drive in_ready = (state != FULL) & rst_n; in_ready SHALL NOT depend combinationally on out_ready or in_valid.
REQ-016 EMPTY: input fire -> ONE, main <= in_data; no fire -> stay.
REQ-017 ONE: input+output fire -> ONE, main <= in_data; input only -> FULL, skid <= in_data; output only -> EMPTY; neither -> stay.
REQ-018 FULL: output fire -> ONE, main <= skid; no output fire -> stay; no input is accepted.
REQ-019 SHALL give latency 1 cycle: word accepted at edge k is on out_data with out_valid=1 after edge k, if buffer was EMPTY.
REQ-020 SHALL sustain one word per cycle when out_ready is held high.
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL deliver words in acceptance order, with no loss or duplication outside flush/reset.
REQ-023 flush=1 at an edge SHALL force state to EMPTY; any input fire in that cycle SHALL be discarded; an output fire in that cycle counts as delivered.
REQ-024 flush SHALL have priority over all other transitions; main/skid contents after flush are don't-care.

Reset
REQ-025 rst_n low SHALL immediately set state EMPTY, out_valid=0, in_ready=0, occupancy=0, main=0, skid=0, hence out_data=0.
REQ-026 On the first edge after rst_n deasserts, in_ready SHALL be 1 and an input fire SHALL be accepted.
REQ-027 Reset asserted mid-operation SHALL discard all held words without waiting for a clock edge.

Verification
REQ-028 Reset then in_data=48'hffffffffffff, in_valid=1, out_ready=1 one cycle -> next cycle out_valid=1, out_data=48'hffffffffffff, occupancy=1.
REQ-029 out_ready=0, push 48'h555555555555 then 48'haaaaaaaaaaaa -> occupancy=2, in_ready=0, out_data=48'h555555555555 stable; release out_ready -> 555.. then aaa.. on consecutive cycles.
REQ-030 Stream 8 words 48'h0..48'h7 with out_ready=1 -> out_valid=1 for 8 consecutive cycles, outputs 0..7 in order, occupancy never exceeds 1.
REQ-031 FULL with 48'h1,48'h2, assert flush with in_valid=1, in_data=48'h3 -> next cycle occupancy=0, out_valid=0; 48'h3 never appears.
REQ-032 rst_n pulled low between edges while FULL -> out_valid=0, in_ready=0, out_data=48'h0 immediately; after release first pushed word is output alone.

Source files
------------

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer between an upstream select mux and a downstream stage.
// in_ready is a pure function of the state register, so it does not depend on out_ready.
module pipe_skid_buf #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // The encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = (state_reg != FULL) & rst_n;
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign occupancy = state_reg;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next = ONE;
          main_next  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          state_next = FULL;
          skid_next  = in_data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_next = ONE;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over everything; register contents are left as computed.
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of a two-word FIFO.
module tb_pipe_skid_buf;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [47:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  occupancy;

  logic [47:0] model_q[$];
  logic [47:0] dut_log[$];
  int          checks;
  int          failures;
  int          max_occ;

  pipe_skid_buf #(.WIDTH(48)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    check_val({tag, ".in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
    check_val({tag, ".occupancy"}, 64'(occupancy), 64'(model_q.size()));
    if (model_q.size() > 0) check_val({tag, ".out_data"}, 64'(out_data), 64'(model_q[0]));
    if (32'(occupancy) > max_occ) max_occ = 32'(occupancy);
  endtask

  // One clock: drive inputs, log what the DUT hands over, advance model, check.
  task automatic cycle(input logic iv, input logic [47:0] id, input logic ordy, input logic fl,
                       input string tag);
    logic exp_in_fire;
    logic exp_out_fire;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    exp_in_fire  = iv && (model_q.size() < 2);
    exp_out_fire = ordy && (model_q.size() > 0);
    #1;
    if (out_valid && out_ready) dut_log.push_back(out_data);
    @(posedge clk);
    if (exp_out_fire) void'(model_q.pop_front());
    if (fl) model_q.delete();
    else if (exp_in_fire) model_q.push_back(id);
    #1;
    check_model(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    max_occ = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset values.
    #2;
    check_val("rst.out_valid", 64'(out_valid), 64'd0);
    check_val("rst.in_ready", 64'(in_ready), 64'd0);
    check_val("rst.occupancy", 64'(occupancy), 64'd0);
    check_val("rst.out_data", 64'(out_data), 64'd0);
    #10 rst_n = 1'b1;

    // First word after reset is accepted and appears one cycle later.
    cycle(1'b1, 48'hffffffffffff, 1'b1, 1'b0, "first");
    check_val("first.out_data", 64'(out_data), 64'h0000ffffffffffff);
    check_val("first.occ", 64'(occupancy), 64'd1);
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "drain0");

    // Fill to FULL with backpressure, then release.
    cycle(1'b1, 48'h555555555555, 1'b0, 1'b0, "bp1");
    cycle(1'b1, 48'haaaaaaaaaaaa, 1'b0, 1'b0, "bp2");
    check_val("bp.occ", 64'(occupancy), 64'd2);
    check_val("bp.in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 48'h123456789abc, 1'b0, 1'b0, "bp3");
    check_val("bp.hold", 64'(out_data), 64'h0000555555555555);
    dut_log.delete();
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "rel1");
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "rel2");
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "rel3");
    check_val("rel.count", 64'(dut_log.size()), 64'd2);
    if (dut_log.size() == 2) begin
      check_val("rel.w0", 64'(dut_log[0]), 64'h0000555555555555);
      check_val("rel.w1", 64'(dut_log[1]), 64'h0000aaaaaaaaaaaa);
    end

    // Streaming at full rate.
    dut_log.delete();
    max_occ = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 48'(i), 1'b1, 1'b0, "stream");
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "stream_end");
    check_val("stream.count", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < dut_log.size() && i < 8; i++)
      check_val("stream.order", 64'(dut_log[i]), 64'(i));
    check_val("stream.max_occ", 64'(max_occ), 64'd1);

    // Flush while FULL discards the concurrently offered word.
    dut_log.delete();
    cycle(1'b1, 48'h1, 1'b0, 1'b0, "fl1");
    cycle(1'b1, 48'h2, 1'b0, 1'b0, "fl2");
    cycle(1'b1, 48'h3, 1'b0, 1'b1, "flush");
    check_val("flush.occ", 64'(occupancy), 64'd0);
    check_val("flush.out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 48'h0, 1'b1, 1'b0, "post_flush");
    check_val("flush.count", 64'(dut_log.size()), 64'd0);

    // Asynchronous reset while FULL.
    cycle(1'b1, 48'h11, 1'b0, 1'b0, "ar1");
    cycle(1'b1, 48'h22, 1'b0, 1'b0, "ar2");
    #3 rst_n = 1'b0;
    #1;
    check_val("arst.out_valid", 64'(out_valid), 64'd0);
    check_val("arst.in_ready", 64'(in_ready), 64'd0);
    check_val("arst.out_data", 64'(out_data), 64'd0);
    check_val("arst.occ", 64'(occupancy), 64'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dut_log.delete();
    cycle(1'b1, 48'h77, 1'b1, 1'b0, "arst_push");
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "arst_pop");
    cycle(1'b0, 48'h0, 1'b1, 1'b0, "arst_idle");
    check_val("arst.count", 64'(dut_log.size()), 64'd1);
    if (dut_log.size() > 0) check_val("arst.word", 64'(dut_log[0]), 64'h77);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            {16'($urandom), 32'($urandom)},
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0),
            "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
